// File: rtl/riscv_rtype_core.sv
// riscv_rtype_core: single-cycle RV32I core executing only R-type ALU instructions.
// Fetches from an internal byte-addressed instruction memory and retires one instruction per clock.

`default_nettype none

module riscv_rtype_imem #(
  parameter int IMEM_BYTES = 256,
  parameter int ADDR_W     = $clog2(IMEM_BYTES)
) (
  input  logic              clk,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       instr
);
  logic [7:0] array [0:IMEM_BYTES-1];

  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;

  // Byte lanes wrap independently so a fetch near the top of memory stays in range.
  assign addr1 = fetch_addr + ADDR_W'(1);
  assign addr2 = fetch_addr + ADDR_W'(2);
  assign addr3 = fetch_addr + ADDR_W'(3);
  assign instr = {array[addr3], array[addr2], array[addr1], array[fetch_addr]};

  always_ff @(posedge clk) begin
    if (load_en) begin
      array[load_addr] <= load_data;
    end
  end
endmodule

module riscv_rtype_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] array [0:31];

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : array[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : array[raddr2];

  // No reset: contents preloaded while the core is held in reset must survive.
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      array[waddr] <= wdata;
    end
  end
endmodule

module riscv_rtype_core #(
  parameter int IMEM_BYTES = 256
) (
  input  logic clk,
  input  logic rst
);
  localparam int ADDR_W = $clog2(IMEM_BYTES);
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        valid;
  logic        we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 32'd0;
    end else begin
      pc <= pc + 32'd4;
    end
  end

  // The load port is never used in operation; contents are preloaded hierarchically.
  riscv_rtype_imem #(
    .IMEM_BYTES (IMEM_BYTES),
    .ADDR_W     (ADDR_W)
  ) instruction_memory (
    .clk        (clk),
    .load_en    (1'b0),
    .load_addr  ('0),
    .load_data  (8'd0),
    .fetch_addr (pc[ADDR_W-1:0]),
    .instr      (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign shamt  = rs2_val[4:0];

  riscv_rtype_regfile regfile (
    .clk    (clk),
    .we     (we),
    .waddr  (rd),
    .wdata  (result),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    result = 32'd0;
    valid  = 1'b0;
    if (opcode == OP_RTYPE) begin
      valid = 1'b1;
      case ({funct7, funct3})
        {7'b0000000, 3'b000}: result = rs1_val + rs2_val;
        {7'b0100000, 3'b000}: result = rs1_val - rs2_val;
        {7'b0000000, 3'b001}: result = rs1_val << shamt;
        {7'b0000000, 3'b010}: result = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
        {7'b0000000, 3'b011}: result = {31'd0, rs1_val < rs2_val};
        {7'b0000000, 3'b100}: result = rs1_val ^ rs2_val;
        {7'b0000000, 3'b101}: result = rs1_val >> shamt;
        {7'b0100000, 3'b101}: result = 32'($signed(rs1_val) >>> shamt);
        {7'b0000000, 3'b110}: result = rs1_val | rs2_val;
        {7'b0000000, 3'b111}: result = rs1_val & rs2_val;
        default:              valid  = 1'b0;
      endcase
    end
  end

  // Gating with rst suppresses the write of an instruction cut short by reset.
  assign we = valid & rst;
endmodule

`default_nettype wire

// File: tb/tb_riscv_rtype_core.sv
// tb_riscv_rtype_core: directed vector table, hand-written reset/wrap sequences and
// random programs checked against a behavioural model of the R-type core.

`default_nettype none

module tb_riscv_rtype_core;
  localparam int IMEM_BYTES = 256;
  localparam logic [31:0] NOP  = 32'h00007033;
  localparam logic [31:0] POIS = 32'hDEADBEEF;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  riscv_rtype_core #(.IMEM_BYTES(IMEM_BYTES)) dut (
    .clk (clk),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic [7:0]  m_imem [0:IMEM_BYTES-1];
  logic [31:0] m_rf   [0:31];
  logic [31:0] m_pc;

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] s2,
                                     input logic [4:0] s1, input logic [2:0] f3,
                                     input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.name = n; v.instr = i; v.a = a; v.b = b; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic put_instr(input int idx, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      dut.instruction_memory.array[(idx * 4 + k) % IMEM_BYTES] = w[k*8 +: 8];
      m_imem[(idx * 4 + k) % IMEM_BYTES] = w[k*8 +: 8];
    end
  endtask

  task automatic set_reg(input int r, input logic [31:0] v);
    dut.regfile.array[r] = v;
    m_rf[r] = v;
  endtask

  task automatic clear_state();
    for (int i = 0; i < IMEM_BYTES / 4; i++) put_instr(i, NOP);
    for (int r = 0; r < 32; r++) set_reg(r, 32'd0);
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference semantics straight from the instruction table.
  function automatic void model_exec(input logic [31:0] ins, input logic [31:0] a,
                                     input logic [31:0] b, output bit wr,
                                     output logic [31:0] res);
    logic [6:0] f7;
    logic [2:0] f3;
    int sh;
    f7 = ins[31:25];
    f3 = ins[14:12];
    sh = int'(b % 32);
    wr = 1'b1;
    res = 32'd0;
    if (ins[6:0] != 7'b0110011) wr = 1'b0;
    else if (f7 == 7'h00) begin
      case (f3)
        3'd0: res = a + b;
        3'd1: res = a << sh;
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = a >> sh;
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
    else if (f7 == 7'h20 && f3 == 3'd5) res = 32'($signed(a) >>> sh);
    else wr = 1'b0;
  endfunction

  task automatic model_step();
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit wr;
    int base;
    base = int'(m_pc % IMEM_BYTES);
    ins = {m_imem[(base + 3) % IMEM_BYTES], m_imem[(base + 2) % IMEM_BYTES],
           m_imem[(base + 1) % IMEM_BYTES], m_imem[base]};
    a = (ins[19:15] == 5'd0) ? 32'd0 : m_rf[ins[19:15]];
    b = (ins[24:20] == 5'd0) ? 32'd0 : m_rf[ins[24:20]];
    model_exec(ins, a, b, wr, res);
    if (wr && ins[11:7] != 5'd0) m_rf[ins[11:7]] = res;
    m_pc = m_pc + 32'd4;
  endtask

  initial begin
    logic [6:0] f7s [0:9];
    logic [2:0] f3s [0:9];
    logic [31:0] w;
    int bad;

    rst = 1'b0;
    f7s = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    f3s = '{3'd0,  3'd0,  3'd1,  3'd2,  3'd3,  3'd4,  3'd5,  3'd5,  3'd6,  3'd7};

    // x3 = op(x1, x2); x3 is preloaded with POIS so a missing write is visible.
    add_vec("add",        rt(7'h00, 2, 1, 0, 3), 32'd5,        32'd7,  32'd12);
    add_vec("add_wrap",   rt(7'h00, 2, 1, 0, 3), 32'hFFFFFFFF, 32'd1,  32'd0);
    add_vec("sub",        rt(7'h20, 2, 1, 0, 3), 32'd0,        32'd1,  32'hFFFFFFFF);
    add_vec("sll_msb",    rt(7'h00, 2, 1, 1, 3), 32'h80000000, 32'd1,  32'd0);
    add_vec("sll_shamt",  rt(7'h00, 2, 1, 1, 3), 32'd3,        32'h24, 32'h30);
    add_vec("slt_neg",    rt(7'h00, 2, 1, 2, 3), 32'h80000000, 32'd1,  32'd1);
    add_vec("slt_pos",    rt(7'h00, 2, 1, 2, 3), 32'd5,        32'd3,  32'd0);
    add_vec("sltu",       rt(7'h00, 2, 1, 3, 3), 32'h80000000, 32'd1,  32'd0);
    add_vec("xor",        rt(7'h00, 2, 1, 4, 3), 32'hF0F0,     32'hFF00, 32'h0FF0);
    add_vec("srl",        rt(7'h00, 2, 1, 5, 3), 32'h80000000, 32'd1,  32'h40000000);
    add_vec("sra",        rt(7'h20, 2, 1, 5, 3), 32'h80000000, 32'd1,  32'hC0000000);
    add_vec("sra_31",     rt(7'h20, 2, 1, 5, 3), 32'h80000000, 32'd31, 32'hFFFFFFFF);
    add_vec("or",         rt(7'h00, 2, 1, 6, 3), 32'h0000F000, 32'h0F, 32'h0000F00F);
    add_vec("and",        rt(7'h00, 2, 1, 7, 3), 32'hFF00FF00, 32'h0FF0, 32'h00000F00);
    add_vec("bad_opcode", {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0010011}, 32'd5, 32'd7, POIS);
    add_vec("bad_mul",    rt(7'h01, 2, 1, 0, 3), 32'd5,        32'd7,  POIS);
    add_vec("bad_f7sll",  rt(7'h20, 2, 1, 1, 3), 32'd5,        32'd7,  POIS);

    for (int i = 0; i < vecs.size(); i++) begin
      enter_reset();
      clear_state();
      set_reg(1, vecs[i].a);
      set_reg(2, vecs[i].b);
      set_reg(3, POIS);
      put_instr(0, vecs[i].instr);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check({vecs[i].name, " x3"}, dut.regfile.array[3], vecs[i].exp);
      check({vecs[i].name, " pc"}, dut.pc, 32'd4);
    end

    // Reset hold with the demo program loaded, then run it.
    enter_reset();
    clear_state();
    for (int r = 1; r <= 7; r++) set_reg(r, 32'(r));
    put_instr(2, 32'h00208433);
    put_instr(3, 32'h404404b3);
    put_instr(4, 32'h00317533);
    put_instr(5, 32'h0041e5b3);
    repeat (5) @(negedge clk);
    check("hold pc", dut.pc, 32'd0);
    for (int r = 1; r <= 11; r++)
      check($sformatf("hold x%0d", r), dut.regfile.array[r], (r <= 7) ? 32'(r) : 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("prog x8", dut.regfile.array[8], 32'd3);
    check("prog x9", dut.regfile.array[9], 32'hFFFFFFFF);
    check("prog x10", dut.regfile.array[10], 32'd2);
    check("prog x11", dut.regfile.array[11], 32'd7);
    check("prog pc", dut.pc, 32'd32);
    for (int r = 1; r <= 7; r++)
      check($sformatf("prog x%0d", r), dut.regfile.array[r], 32'(r));

    // x0 protection.
    enter_reset();
    clear_state();
    set_reg(1, 32'd1);
    set_reg(2, 32'd2);
    set_reg(3, POIS);
    put_instr(0, rt(7'h00, 2, 1, 0, 0));
    put_instr(1, rt(7'h00, 0, 0, 0, 3));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("x0 storage", dut.regfile.array[0], 32'd0);
    check("x0 read", dut.regfile.array[3], 32'd0);

    // Reset mid-run at PC = 0x10 suppresses that cycle's write.
    enter_reset();
    clear_state();
    set_reg(1, 32'd1);
    set_reg(2, 32'd2);
    set_reg(12, 32'h55);
    put_instr(0, rt(7'h00, 2, 1, 0, 8));
    put_instr(1, rt(7'h00, 1, 1, 0, 1));
    put_instr(4, rt(7'h00, 1, 1, 0, 12));
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("mid pc before", dut.pc, 32'h10);
    rst = 1'b0;
    #1;
    check("mid pc async", dut.pc, 32'd0);
    @(negedge clk);
    check("mid x12 suppressed", dut.regfile.array[12], 32'h55);
    check("mid x1 kept", dut.regfile.array[1], 32'd2);
    check("mid x8 kept", dut.regfile.array[8], 32'd3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid rerun x8", dut.regfile.array[8], 32'd4);
    check("mid rerun x1", dut.regfile.array[1], 32'd4);

    // PC wrap: the instruction at 0 runs again after IMEM_BYTES/4 cycles.
    enter_reset();
    clear_state();
    set_reg(1, 32'd1);
    put_instr(0, rt(7'h00, 1, 3, 0, 3));
    @(negedge clk);
    rst = 1'b1;
    repeat (IMEM_BYTES / 4) @(negedge clk);
    check("wrap pc", dut.pc, 32'(IMEM_BYTES));
    check("wrap x3 first", dut.regfile.array[3], 32'd1);
    @(negedge clk);
    check("wrap x3 second", dut.regfile.array[3], 32'd2);

    // Random programs against the model.
    for (int run = 0; run < 3; run++) begin
      enter_reset();
      for (int r = 1; r < 32; r++) set_reg(r, $urandom);
      set_reg(0, 32'd0);
      for (int i = 0; i < IMEM_BYTES / 4; i++) begin
        int k;
        k = $urandom_range(0, 9);
        w = rt(f7s[k], 5'($urandom), 5'($urandom), f3s[k], 5'($urandom));
        if ($urandom_range(0, 7) == 0) w = $urandom;
        put_instr(i, w);
      end
      m_pc = 32'd0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 80; c++) begin
        model_step();
        @(negedge clk);
        check($sformatf("rand%0d pc", run), dut.pc, m_pc);
        bad = 0;
        for (int r = 31; r >= 1; r--)
          if (dut.regfile.array[r] !== m_rf[r]) bad = r;
        check($sformatf("rand%0d cyc%0d x%0d", run, c, bad),
              dut.regfile.array[bad], m_rf[bad]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
